// File: rtl/count_capture.sv
// count_capture: watches an upstream count bus and queues every change of
// value into a small FIFO for a downstream consumer. Each queued sample may
// carry a wrap tag marking a numeric decrease (counter rollover).
//
// Optional feature macro: COUNT_CAPTURE_WRAP_TAG_EN
//   defined   -> each entry stores {wrap, count}; out_wrap shows the head tag
//   undefined -> each entry stores count only; out_wrap is tied low
//
// DEPTH must be a power of two in 2..256 so the pointers wrap naturally.
module count_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     sample_en,
    input  logic                     clr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_wrap,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               drop_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

`ifdef COUNT_CAPTURE_WRAP_TAG_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] r_prev_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic [7:0]       r_drop_cnt;
    logic             r_overflow;
    logic [EW-1:0]    r_mem [DEPTH];

    logic             w_event;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;

    // Handshake and capture decisions; clr suppresses any event in its cycle.
    assign w_event = sample_en && !clr && (count_in != r_prev_count);
    assign w_full  = (r_fill == FILL_FULL);
    assign w_pop   = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

`ifdef COUNT_CAPTURE_WRAP_TAG_EN
    logic w_wrap;
    assign w_wrap   = (count_in < r_prev_count);
    assign w_entry  = {w_wrap, count_in};
    assign w_head   = r_mem[r_rd_ptr];
    assign out_wrap = out_valid && w_head[WIDTH];
`else
    assign w_entry  = count_in;
    assign w_head   = r_mem[r_rd_ptr];
    assign out_wrap = 1'b0;
`endif

    // Head outputs: forced to zero while empty so reset/clear show clean zeros
    // even though the storage array itself keeps stale contents.
    assign out_valid = (r_fill != '0);
    assign out_data  = out_valid ? w_head[WIDTH-1:0] : '0;
    assign fill      = r_fill;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

    // Control state: previous count, pointers, occupancy and drop statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            r_prev_count <= count_in;
            if (clr) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fill     <= '0;
                r_drop_cnt <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_fill <= r_fill + FILL_ONE;
                    2'b01:   r_fill <= r_fill - FILL_ONE;
                    default: r_fill <= r_fill;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // Sample storage: written at the tail on every accepted push.
    // NOTE: the array has no reset; occupancy and the output gating above
    // guarantee stale entries are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

endmodule

// File: tb/tb_count_capture.sv
// Directed self-checking bench for count_capture (WIDTH=8, DEPTH=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_count_capture;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] count_in;
    logic             sample_en;
    logic             clr;
    logic [WIDTH-1:0] out_data;
    logic             out_wrap;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       fill;
    logic [7:0]       drop_cnt;
    logic             overflow;

    int total;
    int bad;

    count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_in  (count_in),
        .sample_en (sample_en),
        .clr       (clr),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        count_in  = '0;
        sample_en = 1'b1;
        clr       = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, out_data, out_wrap, fill, drop_cnt, overflow} !== 23'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%0d w=%b fill=%0d drop=%0d ovf=%b, want all 0",
                     out_valid, out_data, out_wrap, fill, drop_cnt, overflow);
        end
    endtask

    task automatic test_basic_capture();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            count_in = 8'(i);
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i) || fill > 4'd1) begin
                bad++;
                $display("FAIL basic_capture[%0d]: got v=%b d=%0d fill=%0d, want v=1 d=%0d fill<=1",
                         i, out_valid, out_data, fill, i);
            end
        end
        step();
        total++;
        if (out_valid !== 1'b0 || fill !== 4'd0) begin
            bad++;
            $display("FAIL basic_drained: got v=%b fill=%0d, want v=0 fill=0", out_valid, fill);
        end
    endtask

    task automatic test_overflow_and_full_pushpop();
        logic [7:0] exp_q [8];
        exp_q = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd11};
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            count_in = 8'(i);
            step();
            total++;
            if (out_data !== 8'd1) begin
                bad++;
                $display("FAIL head_hold[%0d]: got d=%0d, want 1", i, out_data);
            end
        end
        total++;
        if (fill !== 4'd8 || drop_cnt !== 8'd2 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow: got fill=%0d drop=%0d ovf=%b, want fill=8 drop=2 ovf=1",
                     fill, drop_cnt, overflow);
        end
        // Push and pop together at full.
        out_ready = 1'b1;
        count_in  = 8'd11;
        step();
        total++;
        if (fill !== 4'd8 || drop_cnt !== 8'd2 || out_data !== 8'd2) begin
            bad++;
            $display("FAIL full_pushpop: got fill=%0d drop=%0d d=%0d, want fill=8 drop=2 d=2",
                     fill, drop_cnt, out_data);
        end
        // Drain: 9 and 10 must be absent, 11 must be last.
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                bad++;
                $display("FAIL drain[%0d]: got v=%b d=%0d, want v=1 d=%0d",
                         i, out_valid, out_data, exp_q[i]);
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0 || fill !== 4'd0) begin
            bad++;
            $display("FAIL drain_empty: got v=%b fill=%0d, want v=0 fill=0", out_valid, fill);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] vals [3];
        logic       wraps [3];
        vals = '{8'd254, 8'd255, 8'd0};
`ifdef COUNT_CAPTURE_WRAP_TAG_EN
        wraps = '{1'b0, 1'b0, 1'b1};
`else
        wraps = '{1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            count_in = vals[i];
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || out_wrap !== wraps[i]) begin
                bad++;
                $display("FAIL wrap[%0d]: got v=%b d=%0d w=%b, want v=1 d=%0d w=%b",
                         i, out_valid, out_data, out_wrap, vals[i], wraps[i]);
            end
            step();
        end
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 1; i <= 11; i++) begin
            count_in = 8'(i);
            step();
        end
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        total++;
        if (fill !== 4'd5 || drop_cnt !== 8'd3 || out_data !== 8'd4) begin
            bad++;
            $display("FAIL clr_setup: got fill=%0d drop=%0d d=%0d, want fill=5 drop=3 d=4",
                     fill, drop_cnt, out_data);
        end
        // clr wins over a simultaneous change and pop.
        clr       = 1'b1;
        out_ready = 1'b1;
        count_in  = 8'd50;
        step();
        clr       = 1'b0;
        out_ready = 1'b0;
        total++;
        if (fill !== 4'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL clr: got fill=%0d v=%b drop=%0d ovf=%b, want all 0",
                     fill, out_valid, drop_cnt, overflow);
        end
        step();
        total++;
        if (fill !== 4'd0) begin
            bad++;
            $display("FAIL clr_prev_loaded: got fill=%0d, want 0", fill);
        end
        count_in = 8'd51;
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd51 || fill !== 4'd1) begin
            bad++;
            $display("FAIL clr_resume: got v=%b d=%0d fill=%0d, want v=1 d=51 fill=1",
                     out_valid, out_data, fill);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            count_in = 8'(i);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, out_wrap, fill, drop_cnt, overflow} !== 23'd0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b d=%0d w=%b fill=%0d drop=%0d ovf=%b, want all 0",
                     out_valid, out_data, out_wrap, fill, drop_cnt, overflow);
        end
        count_in = 8'd0;
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || fill !== 4'd0) begin
            bad++;
            $display("FAIL reset_zero_no_event: got v=%b fill=%0d, want v=0 fill=0", out_valid, fill);
        end
        count_in = 8'd7;
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd7) begin
            bad++;
            $display("FAIL reset_first_capture: got v=%b d=%0d, want v=1 d=7", out_valid, out_data);
        end
    endtask

    task automatic test_sample_en();
        do_reset();
        sample_en = 1'b0;
        count_in  = 8'd5;
        step();
        count_in  = 8'd9;
        step();
        total++;
        if (fill !== 4'd0) begin
            bad++;
            $display("FAIL gated: got fill=%0d, want 0", fill);
        end
        sample_en = 1'b1;
        step();
        total++;
        if (fill !== 4'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reenable_no_event: got fill=%0d v=%b, want fill=0 v=0", fill, out_valid);
        end
        count_in = 8'd10;
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd10 || fill !== 4'd1) begin
            bad++;
            $display("FAIL reenable_capture: got v=%b d=%0d fill=%0d, want v=1 d=10 fill=1",
                     out_valid, out_data, fill);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_capture();
        test_overflow_and_full_pushpop();
        test_wrap();
        test_clr();
        test_reset_mid_burst();
        test_sample_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
